count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
Run controller for the team's up-counters. It accepts a terminal-count and mode configuration through a valid/ready handshake, then sequences start, pause, stop and wrap of a WIDTH-bit count. It reports busy status and issues a one-cycle done pulse at each terminal count. It sits between the control/register logic and the counter datapath, and replaces free-running ripple counting where a bounded, restartable count is needed.

Parameters:
WIDTH, 4, bit width of count and limit

Ports:
clk  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state immediately
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted this cycle when high with cfg_valid
cfg_limit  input  WIDTH  terminal count value
cfg_mode  input  1  0 = one-shot, 1 = auto-reload
start  input  1  begin counting from 0 (single-cycle pulse)
stop  input  1  abort and return to IDLE
pause  input  1  level; freezes count while high
tick_en  input  1  count-enable qualifier; one increment per cycle it is high in RUN
count  output  WIDTH  current count value
busy  output  1  high in RUN or HOLD
done  output  1  one-cycle pulse at terminal count

Behaviour:
- Reset values: state=IDLE, count=0, limit_q=all ones, mode_q=0, done=0, busy=0. cfg_ready follows state, so it is 1 in IDLE.
- States are IDLE, RUN, HOLD and DONE. busy = (state==RUN || state==HOLD), registered-equivalent.
- cfg_ready = (state==IDLE || state==DONE). When cfg_valid && cfg_ready are high at a clock edge, limit_q <= cfg_limit and mode_q <= cfg_mode. No configuration is accepted while busy.
- Per-cycle priority: stop > start > pause > tick_en.
- stop in any state: next state IDLE, count <= 0, done <= 0.
- start in IDLE or DONE: count <= 0, next state RUN. start in RUN or HOLD is ignored.
- A cfg handshake and start in the same cycle are both honoured. The new limit applies to this run.
- RUN with pause=1 -> HOLD; the count is not incremented that cycle. HOLD with pause=0 -> RUN. No increment occurs on the exit cycle.
- RUN with tick_en=1 and count != limit_q: count <= count + 1.
- RUN with tick_en=1 and count == limit_q (terminal tick): done <= 1 for exactly one cycle.
  - mode_q=0: count holds at limit_q and next state is DONE.
  - mode_q=1: count <= 0 and the block stays in RUN.
- done latency: done is high in the cycle immediately after the terminal edge. It is low in all other cycles.
- limit_q=0: the count stays 0. In auto mode, every enabled tick is a terminal tick, so done pulses on every tick.
- The count never exceeds limit_q. With limit_q = 2^WIDTH-1, auto-reload wraps to 0 with no overflow flag.
- DONE holds count at limit_q and holds busy=0 until start or stop arrives.
- Reset asserted mid-run forces reset values asynchronously. After reset is released, the block stays in IDLE until start.
- Only mode_q changes the wrap behaviour. A cfg_mode change cannot take effect during a run.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, HOLD, DONE), 2 bits;
  - mode constants MODE_ONESHOT=0 and MODE_AUTO=1;
  - the default WIDTH.
- One natural sub-module: seq_count_reg, a WIDTH-bit register with async reset, synchronous clear, enable and increment. The FSM drives its clear and enable controls.

Test Plan:
- Reset, then cfg limit=3 mode=0, then start with tick_en held at 1 -> count goes 0,1,2,3. done is high one cycle after count reaches 3, the state becomes DONE, busy=0, and count holds at 3.
- limit=2 mode=1 with continuous ticks -> count cycles 0,1,2,0,1,2. done pulses every 3rd cycle and busy stays 1.
- limit=5, assert pause at count=2 for 4 cycles -> count holds at 2 and busy stays 1. After pause is released, counting resumes 3,4,5 and then done pulses.
- stop at count=3 -> next cycle count=0, IDLE, busy=0, no done pulse. Configuration attempted while in RUN -> cfg_ready=0 and limit is unchanged.
- limit=0 mode=1 with tick_en toggling 1,0,1 -> count stays 0 and done pulses only after the enabled ticks.
- Assert reset asynchronously mid-RUN between clock edges -> count=0 and busy=0 immediately, and limit_q becomes all ones. start and stop in the same cycle -> IDLE.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_sequencer_pkg
//  Description : Shared types and constants for the count_sequencer block:
//                run-state encoding, wrap-mode constants and default width.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_sequencer_pkg;

    // Default bit width of the count and the terminal-count limit.
    localparam int DEFAULT_WIDTH = 4;

    // Wrap behaviour at terminal count.
    localparam logic MODE_ONESHOT = 1'b0;  // stop at limit, park in DONE
    localparam logic MODE_AUTO    = 1'b1;  // wrap to 0 and keep running

    // Run-state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/count_sequencer_seq_count_reg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_count_reg
//  Description : WIDTH-bit count register with asynchronous reset,
//                synchronous clear and synchronous increment-enable.
//                Clear has priority over increment.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous active-high reset (count -> 0)
//                clr    - synchronous clear to 0
//                en     - increment by one this cycle
//                count  - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_count_reg
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : count_sequencer
//  Description : Run controller for a bounded, restartable up-counter.
//                Accepts limit/mode over a valid/ready handshake while idle
//                or finished, then sequences start / pause / stop / wrap and
//                issues a one-cycle done pulse at each terminal count.
//  Ports       : clk, reset          - clock, async active-high reset
//                cfg_valid/cfg_ready - configuration handshake
//                cfg_limit, cfg_mode - terminal count, 0=one-shot 1=auto
//                start, stop, pause  - run control (stop>start>pause>tick)
//                tick_en             - count-enable qualifier
//                count, busy, done   - count value, RUN/HOLD flag, tc pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             tick_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_limit;
    logic             r_mode;
    logic             r_done;
    logic             w_done_next;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_cfg_accept;
    logic [WIDTH-1:0] w_count;

    // Configuration is only taken while no run is in progress, so a new
    // limit or mode can never disturb an active count.
    assign cfg_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_cfg_accept = cfg_valid && cfg_ready;
    assign busy         = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign done         = r_done;
    assign count        = w_count;

    seq_count_reg #(
        .WIDTH (WIDTH)
    ) u_count_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .en    (w_cnt_inc),
        .count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_limit <= '1;
            r_mode  <= MODE_ONESHOT;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            if (w_cfg_accept) begin
                r_limit <= cfg_limit;
                r_mode  <= cfg_mode;
            end
        end
    end

    // Next-state / datapath control. Priority: stop > start > pause > tick.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;

        if (stop) begin
            w_state_next = ST_IDLE;
            w_cnt_clr    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_next = ST_RUN;
                        w_cnt_clr    = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Entering HOLD consumes the cycle: no increment.
                    if (pause) begin
                        w_state_next = ST_HOLD;
                    end else if (tick_en) begin
                        if (w_count == r_limit) begin
                            w_done_next = 1'b1;
                            if (r_mode == MODE_AUTO) begin
                                w_cnt_clr = 1'b1;
                            end else begin
                                w_state_next = ST_DONE;
                            end
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Leaving HOLD also consumes the cycle: no increment.
                    if (!pause) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_sequencer
//  Description : Self-checking bench for count_sequencer: directed vector
//                table, asynchronous-reset sequence and randomized stimulus
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sequencer;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_limit;
    logic         cfg_mode;
    logic         start;
    logic         stop;
    logic         pause;
    logic         tick_en;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    count_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_limit (cfg_limit),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .tick_en   (tick_en),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- behavioural reference model ----------------
    // A run is "active" from start until stop or a one-shot terminal tick;
    // "paused" marks a frozen active run; "finished" marks a completed
    // one-shot run parked at its limit.
    bit m_active, m_paused, m_finished, m_mode, m_done;
    int m_count, m_limit;

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_finished = 0;
        m_count = 0; m_limit = (1 << W) - 1; m_mode = 0; m_done = 0;
    endtask

    task automatic model_step(input bit cv, input int lim, input bit md,
                              input bit st, input bit sp, input bit pa, input bit tk);
        bit accept;
        accept = cv && !m_active;
        m_done = 0;
        if (sp) begin
            m_active = 0; m_paused = 0; m_finished = 0; m_count = 0;
        end else if (st && !m_active) begin
            m_active = 1; m_paused = 0; m_finished = 0; m_count = 0;
        end else if (m_active && !m_paused) begin
            if (pa) m_paused = 1;
            else if (tk) begin
                if (m_count == m_limit) begin
                    m_done = 1;
                    if (m_mode) m_count = 0;
                    else begin m_active = 0; m_finished = 1; end
                end else begin
                    m_count = m_count + 1;
                end
            end
        end else if (m_active && m_paused) begin
            if (!pa) m_paused = 0;
        end
        if (accept) begin m_limit = lim; m_mode = md; end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model(input string tag);
        n_checks++;
        if (int'(count) == m_count && !$isunknown(count)) n_pass++;
        else $display("FAIL %s count: got %0d expected %0d (t=%0t)", tag, count, m_count, $time);
        check_bit({tag, " busy"}, busy, m_active);
        check_bit({tag, " done"}, done, m_done);
        check_bit({tag, " cfg_ready"}, cfg_ready, !m_active);
    endtask

    task automatic drive_idle();
        cfg_valid = 0; cfg_limit = '0; cfg_mode = 0;
        start = 0; stop = 0; pause = 0; tick_en = 0;
    endtask

    task automatic step(input bit cv, input logic [W-1:0] lim, input bit md,
                        input bit st, input bit sp, input bit pa, input bit tk,
                        input string tag);
        cfg_valid = cv; cfg_limit = lim; cfg_mode = md;
        start = st; stop = sp; pause = pa; tick_en = tk;
        model_step(cv, int'(lim), md, st, sp, pa, tk);
        @(posedge clk); #1;
        check_model(tag);
    endtask

    // Reset asserted between edges must clear outputs without a clock.
    task automatic async_reset(input string tag);
        drive_idle();
        @(negedge clk); #2;
        reset = 1; #1;
        model_reset();
        check_model(tag);
        @(negedge clk);
        reset = 0;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit cv; logic [W-1:0] lim; bit md;
        bit st; bit sp; bit pa; bit tk;
        logic [W-1:0] e_count; bit e_busy; bit e_done; bit e_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit cv, int lim, bit md, bit st, bit sp, bit pa, bit tk,
                               int ec, bit eb, bit ed, bit er);
        vec_t r;
        r.cv = cv; r.lim = W'(lim); r.md = md; r.st = st; r.sp = sp; r.pa = pa; r.tk = tk;
        r.e_count = W'(ec); r.e_busy = eb; r.e_done = ed; r.e_ready = er;
        return r;
    endfunction

    initial begin
        // one-shot, limit 3
        vecs.push_back(v(1,3,0, 0,0,0,0, 0,0,0,1));
        vecs.push_back(v(0,0,0, 1,0,0,0, 0,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 1,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 2,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 3,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 3,0,1,1));
        vecs.push_back(v(0,0,0, 0,0,0,1, 3,0,0,1));
        // auto, limit 2, cfg and start together from DONE
        vecs.push_back(v(1,2,1, 1,0,0,0, 0,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 1,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 2,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 0,1,1,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 1,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 2,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 0,1,1,0));
        vecs.push_back(v(0,0,0, 0,1,0,1, 0,0,0,1));
        // one-shot, limit 5, pause at 2 for 4 cycles
        vecs.push_back(v(1,5,0, 0,0,0,0, 0,0,0,1));
        vecs.push_back(v(0,0,0, 1,0,0,0, 0,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 1,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 2,1,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(v(0,0,0, 0,0,1,1, 2,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 2,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 3,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 4,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 5,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 5,0,1,1));
        // stop at 3; configuration offered mid-run is refused
        vecs.push_back(v(0,0,0, 1,0,0,0, 0,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 1,1,0,0));
        vecs.push_back(v(1,1,1, 0,0,0,1, 2,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 3,1,0,0));
        vecs.push_back(v(0,0,0, 0,1,0,1, 0,0,0,1));
        // limit still 5, one-shot
        vecs.push_back(v(0,0,0, 1,0,0,0, 0,1,0,0));
        for (int i = 1; i <= 5; i++) vecs.push_back(v(0,0,0, 0,0,0,1, i,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 5,0,1,1));
        // limit 0, auto, ticks 1,0,1
        vecs.push_back(v(1,0,1, 1,0,0,0, 0,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 0,1,1,0));
        vecs.push_back(v(0,0,0, 0,0,0,0, 0,1,0,0));
        vecs.push_back(v(0,0,0, 0,0,0,1, 0,1,1,0));
        // stop and start together -> IDLE
        vecs.push_back(v(0,0,0, 1,1,0,1, 0,0,0,1));
    end

    // ---------------- main sequence ----------------
    initial begin
        drive_idle();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        reset = 0;
        #1;

        foreach (vecs[i]) begin
            vec_t t;
            t = vecs[i];
            step(t.cv, t.lim, t.md, t.st, t.sp, t.pa, t.tk, $sformatf("vec%0d", i));
            n_checks++;
            if (count === t.e_count && busy === t.e_busy && done === t.e_done &&
                cfg_ready === t.e_ready)
                n_pass++;
            else
                $display("FAIL vec%0d table: got cnt=%0d busy=%0b done=%0b rdy=%0b expected cnt=%0d busy=%0b done=%0b rdy=%0b",
                         i, count, busy, done, cfg_ready, t.e_count, t.e_busy, t.e_done, t.e_ready);
        end

        // Async reset mid-RUN; limit must return to all ones, mode to one-shot.
        step(1, 4'd9, 1, 1, 0, 0, 0, "pre_rst_start");
        step(0, 0, 0, 0, 0, 0, 1, "pre_rst_tick");
        step(0, 0, 0, 0, 0, 0, 1, "pre_rst_tick");
        async_reset("async_rst");
        step(0, 0, 0, 0, 0, 0, 1, "post_rst_idle");
        step(0, 0, 0, 0, 0, 1, 1, "post_rst_idle");
        step(0, 0, 0, 1, 0, 0, 0, "post_rst_start");
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 0, 1, "full_range");
        check_bit("full_range_parked", busy, 1'b0);
        n_checks++;
        if (count === 4'hF) n_pass++;
        else $display("FAIL full_range_limit: got %0d expected 15", count);

        // Randomized stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand_rst");
            end else begin
                step($urandom_range(0, 4) == 0,
                     W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 4)),
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 11) == 0,
                     $urandom_range(0, 39) == 0,
                     $urandom_range(0, 6) == 0,
                     $urandom_range(0, 9) < 7,
                     "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
